// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone round-robin arbiter.
//   arb_state_t : arbiter grant state (IDLE, GNT0, GNT1)
//   next_grant  : round-robin pick from two requests and the previous winner
//   *_W         : fixed Wishbone side-band widths
package wshb_arb_pkg;

    localparam int SEL_W = 4;
    localparam int CTI_W = 3;
    localparam int BTE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // last_grant: 0 = master 0 won last, 1 = master 1 won last.
    // On a tie the master that did not win last time is chosen.
    function automatic arb_state_t next_grant(input logic req0,
                                              input logic req1,
                                              input logic last_grant);
        arb_state_t res;
        if (req0 && req1) begin
            res = last_grant ? GNT0 : GNT1;
        end else if (req0) begin
            res = GNT0;
        end else if (req1) begin
            res = GNT1;
        end else begin
            res = IDLE;
        end
        return res;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle.
//   master modport : drives cyc/stb/we/adr/dat_ms/sel/cti/bte, receives ack/dat_sm
//   slave  modport : the reverse
interface wshb_if
    import wshb_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic             cyc;
    logic             stb;
    logic             we;
    logic [AW-1:0]    adr;
    logic [DW-1:0]    dat_ms;
    logic [SEL_W-1:0] sel;
    logic [CTI_W-1:0] cti;
    logic [BTE_W-1:0] bte;
    logic             ack;
    logic [DW-1:0]    dat_sm;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, dat_sm
    );

endinterface

// File: rtl/wshb_rr_arbiter.sv
// Two-master / one-slave Wishbone classic round-robin arbiter.
// m0 is the pattern writer, m1 the VGA framebuffer reader, s the SDRAM
// controller port.
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active high
//   m0, m1    : master-facing ports (requests in, ack/dat_sm out)
//   s         : slave-facing port (muxed request out, ack/dat_sm in)
// Parameters:
//   MAX_BURST : acks per grant before a forced handover to a waiting
//               master; 0 disables forced handover
//   AW, DW    : address / data width
module wshb_rr_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int MAX_BURST = 0,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic   clk,
    input  logic   rst,
    wshb_if.slave  m0,
    wshb_if.slave  m1,
    wshb_if.master s
);

    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((MAX_BURST > 0) ? (MAX_BURST - 1) : 0);

    arb_state_t    state;
    logic          last_grant;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] cnt_inc;
    logic          quota_hit;

    // Quota reached on this ack: the grant may be handed over at this edge,
    // so the transfer being acked completes and nothing is aborted.
    always_comb begin
        quota_hit = (MAX_BURST > 0) && s.ack && (burst_cnt == CNT_LAST);
        if ((MAX_BURST > 0) && (burst_cnt == CNT_LAST)) begin
            cnt_inc = burst_cnt;
        end else begin
            cnt_inc = burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    case (next_grant(m0.cyc, m1.cyc, last_grant))
                        GNT0: begin
                            state      <= GNT0;
                            last_grant <= 1'b0;
                        end
                        GNT1: begin
                            state      <= GNT1;
                            last_grant <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end

                GNT0: begin
                    if (!m0.cyc) begin
                        // Release goes straight to the waiting master, no IDLE bubble.
                        burst_cnt <= '0;
                        if (m1.cyc) begin
                            state      <= GNT1;
                            last_grant <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (quota_hit && m1.cyc) begin
                        state      <= GNT1;
                        last_grant <= 1'b1;
                        burst_cnt  <= '0;
                    end else if (s.ack) begin
                        burst_cnt <= cnt_inc;
                    end
                end

                GNT1: begin
                    if (!m1.cyc) begin
                        burst_cnt <= '0;
                        if (m0.cyc) begin
                            state      <= GNT0;
                            last_grant <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (quota_hit && m0.cyc) begin
                        state      <= GNT0;
                        last_grant <= 1'b0;
                        burst_cnt  <= '0;
                    end else if (s.ack) begin
                        burst_cnt <= cnt_inc;
                    end
                end

                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // Datapath mux follows the registered grant, so an ack arriving in the
    // cycle the grant changes is still routed to the old grantee.
    logic             mux_cyc;
    logic             mux_stb;
    logic             mux_we;
    logic [AW-1:0]    mux_adr;
    logic [DW-1:0]    mux_dat;
    logic [SEL_W-1:0] mux_sel;
    logic [CTI_W-1:0] mux_cti;
    logic [BTE_W-1:0] mux_bte;
    logic             ack0;
    logic             ack1;

    always_comb begin
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        mux_we  = 1'b0;
        mux_adr = '0;
        mux_dat = '0;
        mux_sel = '0;
        mux_cti = '0;
        mux_bte = '0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        case (state)
            GNT0: begin
                mux_cyc = m0.cyc;
                mux_stb = m0.stb;
                mux_we  = m0.we;
                mux_adr = m0.adr;
                mux_dat = m0.dat_ms;
                mux_sel = m0.sel;
                mux_cti = m0.cti;
                mux_bte = m0.bte;
                ack0    = s.ack;
            end
            GNT1: begin
                mux_cyc = m1.cyc;
                mux_stb = m1.stb;
                mux_we  = m1.we;
                mux_adr = m1.adr;
                mux_dat = m1.dat_ms;
                mux_sel = m1.sel;
                mux_cti = m1.cti;
                mux_bte = m1.bte;
                ack1    = s.ack;
            end
            default: ;
        endcase
    end

    assign s.cyc     = mux_cyc;
    assign s.stb     = mux_stb;
    assign s.we      = mux_we;
    assign s.adr     = mux_adr;
    assign s.dat_ms  = mux_dat;
    assign s.sel     = mux_sel;
    assign s.cti     = mux_cti;
    assign s.bte     = mux_bte;

    assign m0.ack    = ack0;
    assign m1.ack    = ack1;
    assign m0.dat_sm = s.dat_sm;
    assign m1.dat_sm = s.dat_sm;

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Bench for wshb_rr_arbiter: two instances (MAX_BURST=0 and MAX_BURST=4)
// share one set of master/slave stimulus. A grant-level model predicts every
// output each cycle; directed phases add hand-computed literal expectations.
module tb_wshb_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // master-side stimulus, index 0 = writer, 1 = reader
    logic        cyc_i [2];
    logic        stb_i [2];
    logic        we_i  [2];
    logic [31:0] adr_i [2];
    logic [31:0] dat_i [2];
    logic [3:0]  sel_i [2];
    logic [2:0]  cti_i [2];
    logic [1:0]  bte_i [2];
    logic        s_ack;
    logic [31:0] s_dat;

    logic [75:0] drv [2];
    assign drv[0] = {cyc_i[0], stb_i[0], we_i[0], adr_i[0], dat_i[0], sel_i[0], cti_i[0], bte_i[0]};
    assign drv[1] = {cyc_i[1], stb_i[1], we_i[1], adr_i[1], dat_i[1], sel_i[1], cti_i[1], bte_i[1]};

    wshb_if #(.AW(32), .DW(32)) m0a ();
    wshb_if #(.AW(32), .DW(32)) m1a ();
    wshb_if #(.AW(32), .DW(32)) sa  ();
    wshb_if #(.AW(32), .DW(32)) m0b ();
    wshb_if #(.AW(32), .DW(32)) m1b ();
    wshb_if #(.AW(32), .DW(32)) sb  ();

    assign {m0a.cyc, m0a.stb, m0a.we, m0a.adr, m0a.dat_ms, m0a.sel, m0a.cti, m0a.bte} = drv[0];
    assign {m1a.cyc, m1a.stb, m1a.we, m1a.adr, m1a.dat_ms, m1a.sel, m1a.cti, m1a.bte} = drv[1];
    assign {m0b.cyc, m0b.stb, m0b.we, m0b.adr, m0b.dat_ms, m0b.sel, m0b.cti, m0b.bte} = drv[0];
    assign {m1b.cyc, m1b.stb, m1b.we, m1b.adr, m1b.dat_ms, m1b.sel, m1b.cti, m1b.bte} = drv[1];
    assign sa.ack    = s_ack;
    assign sa.dat_sm = s_dat;
    assign sb.ack    = s_ack;
    assign sb.dat_sm = s_dat;

    wshb_rr_arbiter #(.MAX_BURST(0), .AW(32), .DW(32)) dut_a (
        .clk(clk), .rst(rst), .m0(m0a), .m1(m1a), .s(sa)
    );
    wshb_rr_arbiter #(.MAX_BURST(4), .AW(32), .DW(32)) dut_b (
        .clk(clk), .rst(rst), .m0(m0b), .m1(m1b), .s(sb)
    );

    logic [141:0] obs_a;
    logic [141:0] obs_b;
    assign obs_a = {sa.cyc, sa.stb, sa.we, sa.adr, sa.dat_ms, sa.sel, sa.cti, sa.bte,
                    m0a.ack, m1a.ack, m0a.dat_sm, m1a.dat_sm};
    assign obs_b = {sb.cyc, sb.stb, sb.we, sb.adr, sb.dat_ms, sb.sel, sb.cti, sb.bte,
                    m0b.ack, m1b.ack, m0b.dat_sm, m1b.dat_sm};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [141:0] act, input logic [141:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- grant-level reference model ----------------
    // g: current owner (-1 none), run: acks seen in this grant (unbounded),
    // last: most recent winner.
    typedef struct {
        int g;
        int run;
        int last;
    } mstate_t;

    mstate_t ms [2];
    int quota [2] = '{0, 4};

    function automatic mstate_t model_next(input mstate_t cur, input int q);
        mstate_t n;
        int o;
        n = cur;
        if (cur.g < 0) begin
            if (cyc_i[0] && cyc_i[1]) n.g = 1 - cur.last;
            else if (cyc_i[0])        n.g = 0;
            else if (cyc_i[1])        n.g = 1;
            else                      n.g = -1;
        end else begin
            o = 1 - cur.g;
            if (!cyc_i[cur.g])
                n.g = cyc_i[o] ? o : -1;
            else if (q > 0 && s_ack && (cur.run + 1 >= q) && cyc_i[o])
                n.g = o;
            else
                n.g = cur.g;
        end
        if (n.g < 0 || n.g != cur.g) n.run = 0;
        else if (s_ack)              n.run = cur.run + 1;
        if (n.g >= 0 && n.g != cur.g) n.last = n.g;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ms[0] <= '{g: -1, run: 0, last: 1};
            ms[1] <= '{g: -1, run: 0, last: 1};
        end else begin
            ms[0] <= model_next(ms[0], quota[0]);
            ms[1] <= model_next(ms[1], quota[1]);
        end
    end

    function automatic logic [141:0] expect_vec(input int g);
        logic [75:0] bus;
        logic        a0;
        logic        a1;
        bus = (g < 0) ? 76'd0 : drv[g];
        a0  = (g == 0) && s_ack;
        a1  = (g == 1) && s_ack;
        return {bus, a0, a1, s_dat, s_dat};
    endfunction

    // ---------------- per-cycle compare process ----------------
    int obs_acks [2] = '{0, 0};
    int exp_acks [2] = '{0, 0};

    initial begin
        forever begin
            @(negedge clk);
            check("dut_a_outputs", obs_a, expect_vec(ms[0].g));
            check("dut_b_outputs", obs_b, expect_vec(ms[1].g));
            obs_acks[0] += int'(m0a.ack) + int'(m1a.ack);
            obs_acks[1] += int'(m0b.ack) + int'(m1b.ack);
            if (s_ack && ms[0].g >= 0) exp_acks[0]++;
            if (s_ack && ms[1].g >= 0) exp_acks[1]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            cyc_i[k] = 1'b0; stb_i[k] = 1'b0; we_i[k] = 1'b0;
            adr_i[k] = '0;   dat_i[k] = '0;   sel_i[k] = '0;
            cti_i[k] = '0;   bte_i[k] = '0;
        end
        s_ack = 1'b0;
        s_dat = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    int cnt0, cnt1, bad;
    logic [11:0] pat;

    initial begin
        idle_inputs();
        #1 rst = 1'b1;
        s_ack = 1'b1;
        @(negedge clk);
        check("reset_idle", {sa.cyc, sa.stb, m0a.ack, m1a.ack, sb.cyc, sb.stb, m0b.ack, m1b.ack}, 8'h00);

        // -- m0 alone, slave acks every cycle
        do_reset();
        cyc_i[0] = 1'b1; stb_i[0] = 1'b1; we_i[0] = 1'b1; adr_i[0] = 32'h0000_1000;
        s_ack = 1'b1; s_dat = 32'h1234_5678;
        cnt0 = 0; cnt1 = 0;
        @(negedge clk);
        check("t1_scyc_latency", sa.cyc, 1'b0);
        cnt0 += int'(m0a.ack); cnt1 += int'(m1a.ack);
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            @(negedge clk);
            if (i == 1) check("t1_scyc_rise", sa.cyc, 1'b1);
            cnt0 += int'(m0a.ack); cnt1 += int'(m1a.ack);
        end
        next_cycle();
        cyc_i[0] = 1'b0; stb_i[0] = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        cnt0 += int'(m0a.ack); cnt1 += int'(m1a.ack);
        check("t1_m0_acks", cnt0, 10);
        check("t1_m1_acks", cnt1, 0);

        // -- simultaneous requests, m0 drops for one cycle after 63 acks
        do_reset();
        cyc_i[0] = 1'b1; stb_i[0] = 1'b1; adr_i[0] = 32'hA000_0000;
        cyc_i[1] = 1'b1; stb_i[1] = 1'b1; adr_i[1] = 32'hB000_0000;
        s_ack = 1'b1;
        cnt0 = 0;
        @(negedge clk);
        cnt0 += int'(m0a.ack);
        for (int i = 1; i <= 63; i++) begin
            next_cycle();
            @(negedge clk);
            if (i == 1) check("t2_first_grant_adr", sa.adr, 32'hA000_0000);
            cnt0 += int'(m0a.ack);
        end
        next_cycle();
        cyc_i[0] = 1'b0; stb_i[0] = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        cnt0 += int'(m0a.ack);
        next_cycle();
        cyc_i[0] = 1'b1; stb_i[0] = 1'b1; s_ack = 1'b1;
        @(negedge clk);
        check("t2_m0_acks", cnt0, 63);
        check("t2_gnt1_adr", sa.adr, 32'hB000_0000);
        check("t2_gnt1_ack", {m0a.ack, m1a.ack}, 2'b01);

        // -- MAX_BURST=4 instance, both masters always requesting
        do_reset();
        cyc_i[0] = 1'b1; stb_i[0] = 1'b1; adr_i[0] = 32'h0000_0040;
        cyc_i[1] = 1'b1; stb_i[1] = 1'b1; adr_i[1] = 32'h0000_0080;
        s_ack = 1'b1;
        pat = '0; bad = 0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            @(negedge clk);
            pat[i] = m1b.ack;
            if (!sb.cyc || (m0b.ack == m1b.ack)) bad++;
        end
        check("t3_grant_pattern", pat, 12'h0F0);
        check("t3_no_gap", bad, 0);

        // -- asynchronous reset while m1 holds the grant with an ack pending
        do_reset();
        cyc_i[1] = 1'b1; stb_i[1] = 1'b1; adr_i[1] = 32'hC000_0000;
        next_cycle();
        next_cycle();
        s_ack = 1'b1;
        #2;
        check("t4_pre_reset", {sa.cyc, sa.stb, m1a.ack, sb.cyc, sb.stb, m1b.ack}, 6'h3F);
        rst = 1'b1;
        #1;
        check("t4_async_reset", {sa.cyc, sa.stb, m0a.ack, m1a.ack, sb.cyc, sb.stb, m0b.ack, m1b.ack}, 8'h00);
        cyc_i[0] = 1'b1; stb_i[0] = 1'b1; adr_i[0] = 32'hD000_0000;
        s_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        check("t4_m0_first_a", sa.adr, 32'hD000_0000);
        check("t4_m0_first_b", sb.adr, 32'hD000_0000);

        // -- spurious slave ack with nobody requesting
        do_reset();
        s_ack = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            @(negedge clk);
            bad += int'(m0a.ack) + int'(m1a.ack) + int'(m0b.ack) + int'(m1b.ack)
                 + int'(sa.cyc) + int'(sb.cyc);
        end
        check("t5_spurious_ack", bad, 0);

        // -- randomized traffic with occasional mid-cycle reset pulses
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            for (int k = 0; k < 2; k++) begin
                if (cyc_i[k]) begin
                    if ($urandom_range(7) == 0) cyc_i[k] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    cyc_i[k] = 1'b1;
                end
                stb_i[k] = cyc_i[k] & ($urandom_range(3) != 0);
                we_i[k]  = 1'($urandom);
                adr_i[k] = $urandom;
                dat_i[k] = $urandom;
                sel_i[k] = 4'($urandom);
                cti_i[k] = 3'($urandom);
                bte_i[k] = 2'($urandom);
            end
            s_ack = 1'($urandom);
            s_dat = $urandom;
            if ($urandom_range(499) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        @(negedge clk);
        check("ack_sum_a", obs_acks[0], exp_acks[0]);
        check("ack_sum_b", obs_acks[1], exp_acks[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wshb_rr_arbiter.md
Name: wshb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter directly downstream of the pattern writer (m0, SDRAM writes) and the VGA framebuffer reader (m1, SDRAM reads).
- Drives the single SDRAM controller slave port.
- Uses round-robin grant with re-arbitration whenever the granted master drops cyc.
- Can optionally force a handover after MAX_BURST acks so neither master starves the other.

Parameters:
- MAX_BURST, 0, acks allowed per grant before a forced handover when the other master requests; 0 disables forced handover.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-high.
- m0  wshb_if.slave  interface  master 0 (writer): cyc, stb, we, adr[AW], dat_ms[DW], sel[4], cti[3], bte[2] in; ack, dat_sm[DW] out.
- m1  wshb_if.slave  interface  master 1 (VGA reader): same signal set as m0.
- s  wshb_if.master  interface  to SDRAM slave: cyc, stb, we, adr, dat_ms, sel, cti, bte out; ack, dat_sm in.

Behaviour:
- States: IDLE, GNT0, GNT1. The grant is registered; a last_grant flag holds the most recent winner; burst_cnt counts acks received in the current grant.
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE, last_grant=1 (so m0 wins the first tie), burst_cnt=0.
  - s.cyc=s.stb=0; m0.ack=m1.ack=0.
- IDLE:
  - s.cyc=s.stb=0; s.we, s.adr, s.dat_ms, s.sel, s.cti, s.bte all 0.
  - Requests are m0.cyc and m1.cyc, sampled at the edge.
  - Single requester: grant it.
  - Both request: grant the master that is not last_grant.
  - No request: stay in IDLE.
  - Arbitration latency is one cycle: a request asserted in cycle N is presented to s in cycle N+1.
- GNTx, datapath:
  - Combinationally mux mx.{cyc, stb, we, adr, dat_ms, sel, cti, bte} onto s.
  - mx.ack = s.ack; the non-granted master's ack is 0.
  - s.dat_sm is broadcast to both m0.dat_sm and m1.dat_sm.
- GNTx, counter and flag:
  - burst_cnt increments on each s.ack while in GNTx.
  - last_grant=x is set on entry to GNTx.
- GNTx, release when mx.cyc=0 at the edge:
  - Other master requesting: go directly to GNTother. There is no IDLE bubble, so the writer's one-cycle fair-play gap hands the bus to the reader on the next cycle.
  - Otherwise: go to IDLE.
- GNTx, forced handover:
  - Condition: MAX_BURST>0, s.ack=1, burst_cnt==MAX_BURST-1, other master requesting.
  - Next state is GNTother. The switch happens only on an ack edge, so no transfer is ever aborted.
  - The preempted master keeps stb/adr/dat asserted and simply waits; it sees no ack until it is granted again.
- Ack attribution:
  - An ack in the cycle of a grant change belongs to the old grantee, because the grant is registered.
  - The new grantee can receive its first ack no earlier than the following cycle.
- burst_cnt:
  - Width is $clog2(MAX_BURST+1) bits; minimum 1 bit.
  - Clears to 0 on every grant change and on entry to IDLE.
  - Saturates at MAX_BURST-1 when MAX_BURST>0.
- Simultaneous events:
  - Granted master drops cyc in the same cycle the other raises cyc: handover on that edge.
  - Both drop cyc: IDLE.
  - s.ack in IDLE: ignored, no ack forwarded.
- The arbiter never holds the grant with both masters idle.

Decomposition:
- Package wshb_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t.
  - A function next_grant(req0, req1, last_grant) returning arb_state_t.
- No sub-module: the state register, counter and mux stay in one module.

Test Plan:
- m0 only, cyc/stb=1, slave acks every cycle for 10 transfers → s.cyc rises 1 cycle after m0.cyc; 10 acks reach m0; m1.ack stays 0.
- m0 and m1 request in the same cycle after reset → GNT0 first; m0 drops cyc for 1 cycle after 63 acks → GNT1 on the next edge; s.adr equals m1.adr.
- MAX_BURST=4, both masters hold cyc continuously → grants alternate every 4 acks: 0,0,0,0,1,1,1,1,0...; no cycle with s.cyc=0.
- Ack in the switch cycle → exactly that ack goes to the old grantee; the new grantee's first possible ack is 1 cycle later; acks counted at m0 plus m1 equal acks at s.
- rst pulsed while GNT1 with an ack pending → s.cyc, s.stb, m0.ack, m1.ack all 0 asynchronously; after release with both requesting, m0 is granted first.
- Both masters idle with the slave driving spurious ack=1 → no ack forwarded; state stays IDLE.
